// File: rtl/char_disp_queue.sv
// Buffered hex character display: a valid/ready FIFO feeds a two-state show/idle sequencer.
// Each popped code is shown on NDIG active-low seven-segment digits for 2^DIVLOG cycles.
module char_disp_queue #(
  parameter int CW         = 7,
  parameter int DEPTH      = 8,
  parameter int DIVLOG     = 20,
  parameter int NDIG       = 2,
  parameter int BLANK_IDLE = 1
) (
  input  logic                   phi,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [CW-1:0]          in_char,
  output logic                   in_ready,
  output logic [7*NDIG-1:0]      disp,
  output logic                   led_busy,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SHOW} state_t;

  // Active-low segment pattern for one hex nibble, bit 0 = seg a ... bit 6 = seg g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] on;
    case (n)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic logic [7*NDIG-1:0] render(input logic [CW-1:0] c);
    logic [4*NDIG-1:0] ext;
    logic [7*NDIG-1:0] r;
    ext         = '0;
    ext[CW-1:0] = c;
    r           = '1;
    for (int unsigned k = 0; k < NDIG; k++) r[7*k +: 7] = seg7(ext[4*k +: 4]);
    return r;
  endfunction

  localparam logic [7*NDIG-1:0] DISP_RST = (BLANK_IDLE != 0) ? '1 : render(CW'(0));

  state_t            state_q, state_d;
  logic [CW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       fill_q;
  logic [DIVLOG-1:0] hold_q, hold_d;
  logic [CW-1:0]     dchar_q, dchar_d;
  logic [7*NDIG-1:0] disp_q, disp_d;
  logic              push, pop;

  assign in_ready = (fill_q != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign fill     = fill_q;
  assign disp     = disp_q;
  assign led_busy = (state_q == SHOW);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dchar_d = dchar_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_q != '0) begin
          pop     = 1'b1;
          dchar_d = mem_q[rptr_q];
          hold_d  = '0;
          state_d = SHOW;
        end
      end
      default: begin
        if (hold_q == '1) begin
          if (fill_q != '0) begin
            pop     = 1'b1;
            dchar_d = mem_q[rptr_q];
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + DIVLOG'(1);
        end
      end
    endcase
    // Output register is loaded from next-state values so a pop shows on the same edge.
    if (state_d == SHOW || BLANK_IDLE == 0) disp_d = render(dchar_d);
    else                                    disp_d = '1;
  end

  always_ff @(posedge phi) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      dchar_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      disp_q  <= DISP_RST;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dchar_q <= dchar_d;
      disp_q  <= disp_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      fill_q <= fill_q + (AW+1)'(1);
      else if (pop && !push) fill_q <= fill_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge phi) begin
    if (push) mem_q[wptr_q] <= in_char;
  end

endmodule

// File: tb/tb_char_disp_queue.sv
// Randomised bench for char_disp_queue against a queue-based display timeline model.
module tb_char_disp_queue;

  logic        phi = 1'b0;
  logic        reset, in_valid, in_ready, led_busy;
  logic [6:0]  in_char;
  logic [13:0] disp;
  logic [2:0]  fill;

  logic        reset1, in_valid1, in_ready1, led_busy1;
  logic [6:0]  in_char1;
  logic [13:0] disp1;
  logic [2:0]  fill1;

  int checks = 0;
  int failures = 0;

  always #5 phi = ~phi;

  char_disp_queue #(.CW(7), .DEPTH(4), .DIVLOG(2), .NDIG(2), .BLANK_IDLE(1)) dut (
    .phi(phi), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .disp(disp), .led_busy(led_busy), .fill(fill)
  );

  char_disp_queue #(.CW(7), .DEPTH(4), .DIVLOG(2), .NDIG(2), .BLANK_IDLE(0)) dut_keep (
    .phi(phi), .reset(reset1), .in_valid(in_valid1), .in_char(in_char1),
    .in_ready(in_ready1), .disp(disp1), .led_busy(led_busy1), .fill(fill1)
  );

  // Reference model: pending characters, character on show and cycles it has been shown.
  logic [6:0] mq[$];
  bit         m_busy;
  int         m_age;
  logic [6:0] m_cur;

  // Lit segments per hex digit, by segment letter.
  string SEGS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] tb_seg(input int n);
    logic [6:0] r;
    string s;
    r = 7'h7F;
    s = SEGS[n];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic logic [13:0] tb_disp(input logic [6:0] c);
    return {tb_seg(int'(c) / 16), tb_seg(int'(c) % 16)};
  endfunction

  function automatic logic [18:0] expect_vec();
    logic [13:0] d;
    d = m_busy ? tb_disp(m_cur) : 14'h3FFF;
    return {d, m_busy, 3'(mq.size()), mq.size() != 4};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_age  = 0;
    m_cur  = '0;
  endtask

  task automatic model_edge(input logic v, input logic [6:0] c);
    int pre;
    pre = mq.size();
    if (m_busy) begin
      m_age++;
      if (m_age == 4) begin
        if (pre > 0) begin m_cur = mq.pop_front(); m_age = 0; end
        else m_busy = 0;
      end
    end else if (pre > 0) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
      m_age  = 0;
    end
    if (v && pre < 4) mq.push_back(c);
  endtask

  task automatic step(input logic v, input logic [6:0] c);
    in_valid = v;
    in_char  = c;
    @(posedge phi);
    model_edge(v, c);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_char = '0;
    repeat (2) @(posedge phi);
    model_reset();
    #1;
    checks++;
    if ({disp, in_ready, fill, led_busy} !== {14'h3FFF, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset got disp=%h rdy=%b fill=%0d busy=%b", disp, in_ready, fill, led_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, 7'h41);
    step(1'b0, '0);
    checks++;
    if ({disp, led_busy} !== {14'b0011001_1111001, 1'b1}) begin
      failures++;
      $display("FAIL single_41 got disp=%b busy=%b exp disp=%b busy=1", disp, led_busy, 14'b0011001_1111001);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0);
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL single_hold cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
    end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7'($urandom));
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL fill_push cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
    end
    checks++;
    if ({fill, in_ready} !== {3'd4, 1'b0}) begin
      failures++;
      $display("FAIL full_flag got fill=%0d rdy=%b exp fill=4 rdy=0", fill, in_ready);
    end
    step(1'b1, 7'h55);
    for (int i = 0; i < 22; i++) begin
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
      step(1'b0, '0);
    end
  endtask

  task automatic test_simul();
    int pushed;
    for (int i = 0; i < 3; i++) step(1'b1, 7'($urandom));
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, 7'($urandom));
    checks++;
    if ({fill, led_busy} !== {3'd2, 1'b1}) begin
      failures++;
      $display("FAIL simul_pushpop got fill=%0d busy=%b exp fill=2 busy=1", fill, led_busy);
    end
    pushed = 4;
    for (int i = 0; i < 60; i++) begin
      logic v;
      v = (pushed < 10) && in_ready && ($urandom_range(0, 2) != 0);
      if (v) pushed++;
      step(v, 7'($urandom));
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL simul_wrap cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, 7'($urandom));
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (12) step(1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 7'h10 + 7'(i));
    reset = 1'b1;
    @(posedge phi);
    model_reset();
    #1;
    reset = 1'b0;
    checks++;
    if ({disp, fill, led_busy, in_ready} !== {14'h3FFF, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got disp=%h fill=%0d busy=%b", disp, fill, led_busy);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      checks++;
      if ({disp, led_busy, fill, in_ready} !== expect_vec()) begin
        failures++;
        $display("FAIL reset_discard cyc=%0d got=%h exp=%h", i, {disp, led_busy, fill, in_ready}, expect_vec());
      end
    end
  endtask

  task automatic test_retain();
    reset1 = 1'b1;
    in_valid1 = 1'b0;
    in_char1 = '0;
    repeat (2) @(posedge phi);
    #1;
    reset1 = 1'b0;
    checks++;
    if ({disp1, led_busy1} !== {tb_disp(7'h00), 1'b0}) begin
      failures++;
      $display("FAIL retain_reset got disp=%h exp=%h", disp1, tb_disp(7'h00));
    end
    in_valid1 = 1'b1;
    in_char1  = 7'h7F;
    @(posedge phi);
    #1;
    in_valid1 = 1'b0;
    @(posedge phi);
    #1;
    checks++;
    if ({disp1, led_busy1} !== {tb_disp(7'h7F), 1'b1}) begin
      failures++;
      $display("FAIL retain_show got disp=%h busy=%b exp=%h busy=1", disp1, led_busy1, tb_disp(7'h7F));
    end
    repeat (6) @(posedge phi);
    #1;
    checks++;
    if ({disp1, led_busy1, fill1} !== {tb_disp(7'h7F), 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL retain_idle got disp=%h busy=%b exp=%h busy=0", disp1, led_busy1, tb_disp(7'h7F));
    end
  endtask

  initial begin
    reset1 = 1'b1;
    in_valid1 = 1'b0;
    in_char1 = '0;
    test_reset();
    test_single();
    test_fill_full();
    test_simul();
    test_random();
    test_reset_mid();
    test_retain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
